// File: rtl/cmd_link_uart.sv
// cmd_link_uart: 8N1 UART link that assembles two RX bytes into a 16-bit command and serialises 8-bit responses on TX.
// Optional build macro CMD_TIMEOUT_EN abandons a half-received command after TIMEOUT_CYC idle cycles in WAIT_L.
module cmd_link_uart #(
   parameter int BAUD_DIV    = 2604,
   parameter int TIMEOUT_CYC = 52080
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        resp_sent
);
   localparam int BW = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2 - 1);
   localparam logic [BW-1:0] LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] PEN  = BW'(BAUD_DIV - 2);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} bit_st_t;
   typedef enum logic [1:0] {A_WAIT_H, A_WAIT_L, A_FULL} asm_st_t;

   logic          rx_s1, rx_s2, rx_s3;
   bit_st_t       rx_st;
   logic [BW-1:0] rx_cnt;
   logic [3:0]    rx_bit;
   logic [7:0]    rx_byte;
   logic          rx_valid;

   asm_st_t       as_st;
`ifdef CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_cnt;
`endif

   bit_st_t       tx_st;
   logic [BW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic [7:0]    tx_sh;

   // Two-flop synchroniser plus one delayed copy for start-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) {rx_s1, rx_s2, rx_s3} <= 3'b111;
      else        {rx_s1, rx_s2, rx_s3} <= {RX, rx_s1, rx_s2};
   end

   // Receive bit engine: mid-bit sampling, false-start rejection, framing check on stop bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_st    <= S_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (rx_st)
            S_IDLE: if (rx_s3 && !rx_s2) begin
               rx_st  <= S_START;
               rx_cnt <= '0;
            end
            S_START: if (rx_cnt == HALF) begin
               rx_st  <= rx_s2 ? S_IDLE : S_DATA;
               rx_cnt <= '0;
               rx_bit <= '0;
            end else rx_cnt <= rx_cnt + 1'b1;
            S_DATA: if (rx_cnt == LAST) begin
               rx_byte <= {rx_s2, rx_byte[7:1]};
               rx_cnt  <= '0;
               rx_bit  <= rx_bit + 1'b1;
               if (rx_bit == 4'd7) rx_st <= S_STOP;
            end else rx_cnt <= rx_cnt + 1'b1;
            S_STOP: if (rx_cnt == LAST) begin
               rx_valid <= rx_s2;
               rx_st    <= S_IDLE;
            end else rx_cnt <= rx_cnt + 1'b1;
            default: rx_st <= S_IDLE;
         endcase
      end
   end

   // Command assembler: high byte then low byte, held until the consumer clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         as_st   <= A_WAIT_H;
         cmd     <= '0;
         cmd_rdy <= 1'b0;
`ifdef CMD_TIMEOUT_EN
         to_cnt  <= '0;
`endif
      end else begin
         case (as_st)
            A_WAIT_H: if (rx_valid) begin
               cmd[15:8] <= rx_byte;
               as_st     <= A_WAIT_L;
`ifdef CMD_TIMEOUT_EN
               to_cnt    <= '0;
`endif
            end
            A_WAIT_L: if (rx_valid) begin
               cmd[7:0] <= rx_byte;
               cmd_rdy  <= 1'b1;
               as_st    <= A_FULL;
            end
`ifdef CMD_TIMEOUT_EN
            else if (to_cnt == TW'(TIMEOUT_CYC - 1)) as_st <= A_WAIT_H;
            else to_cnt <= to_cnt + 1'b1;
`endif
            A_FULL: if (clr_cmd_rdy) begin
               cmd_rdy <= 1'b0;
               as_st   <= A_WAIT_H;
            end
            default: as_st <= A_WAIT_H;
         endcase
      end
   end

   // Transmit bit engine: resp_sent is raised one cycle early so it coincides with the last stop cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_st     <= S_IDLE;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_sh     <= '0;
         TX        <= 1'b1;
         resp_sent <= 1'b0;
      end else begin
         resp_sent <= 1'b0;
         case (tx_st)
            S_IDLE: if (send_resp) begin
               tx_sh  <= resp;
               TX     <= 1'b0;
               tx_cnt <= '0;
               tx_st  <= S_START;
            end
            S_START: if (tx_cnt == LAST) begin
               TX     <= tx_sh[0];
               tx_sh  <= tx_sh >> 1;
               tx_bit <= '0;
               tx_cnt <= '0;
               tx_st  <= S_DATA;
            end else tx_cnt <= tx_cnt + 1'b1;
            S_DATA: if (tx_cnt == LAST) begin
               tx_cnt <= '0;
               TX     <= (tx_bit == 4'd7) ? 1'b1 : tx_sh[0];
               tx_sh  <= tx_sh >> 1;
               tx_bit <= tx_bit + 1'b1;
               if (tx_bit == 4'd7) tx_st <= S_STOP;
            end else tx_cnt <= tx_cnt + 1'b1;
            S_STOP: begin
               tx_cnt <= tx_cnt + 1'b1;
               if (tx_cnt == PEN) resp_sent <= 1'b1;
               if (tx_cnt == LAST) tx_st <= S_IDLE;
            end
            default: tx_st <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cmd_link_uart.sv
// tb_cmd_link_uart: directed self-checking bench for cmd_link_uart at BAUD_DIV=16, TIMEOUT_CYC=400.
module tb_cmd_link_uart;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        RX;
   logic        TX;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic [7:0]  resp;
   logic        send_resp;
   logic        resp_sent;
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  txb;
   logic        exp_tx;

   cmd_link_uart #(.BAUD_DIV(16), .TIMEOUT_CYC(400)) dut (
      .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      RX = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (16) @(negedge clk);
      end
      RX = stop;
      repeat (16) @(negedge clk);
      RX = 1'b1;
      if (!stop) repeat (16) @(negedge clk);
   endtask

   task automatic clear_cmd();
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", TX, 1);
      check("rst_cmd", cmd, 16'h0000);
      check("rst_cmd_rdy", cmd_rdy, 0);
      check("rst_resp_sent", resp_sent, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      send_byte(8'h41, 1'b1);
      check("half_cmd_rdy", cmd_rdy, 0);
      send_byte(8'h23, 1'b1);
      check("cmd_4123", cmd, 16'h4123);
      check("rdy_4123", cmd_rdy, 1);

      send_byte(8'hFF, 1'b1);
      check("overrun_cmd", cmd, 16'h4123);
      check("overrun_rdy", cmd_rdy, 1);
      clear_cmd();
      check("clr_rdy", cmd_rdy, 0);
      check("clr_keeps_cmd", cmd, 16'h4123);
      send_byte(8'h80, 1'b1);
      send_byte(8'h06, 1'b1);
      check("cmd_8006", cmd, 16'h8006);
      check("rdy_8006", cmd_rdy, 1);
      clear_cmd();

      send_byte(8'h5A, 1'b0);
      check("frame_err_rdy", cmd_rdy, 0);
      RX = 1'b0;
      repeat (4) @(negedge clk);
      RX = 1'b1;
      repeat (30) @(negedge clk);
      send_byte(8'h01, 1'b1);
      check("glitch_rdy", cmd_rdy, 0);
      send_byte(8'h02, 1'b1);
      check("cmd_0102", cmd, 16'h0102);
      check("rdy_0102", cmd_rdy, 1);
      clear_cmd();

      txb = 8'hA5;
      resp = 8'hA5; send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0; resp = 8'h00;
      for (int c = 0; c < 170; c++) begin
         if (c == 50) send_resp = 1'b1;
         if (c == 51) send_resp = 1'b0;
         exp_tx = (c < 16) ? 1'b0 : (c < 144) ? txb[(c - 16) / 16] : 1'b1;
         check("tx_bit", TX, exp_tx);
         check("resp_sent", resp_sent, c == 159);
         @(negedge clk);
      end

      send_byte(8'h11, 1'b1);
      repeat (500) @(negedge clk);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
`ifdef CMD_TIMEOUT_EN
      check("timeout_cmd", cmd, 16'h2233);
`else
      check("no_timeout_cmd", cmd, 16'h1122);
`endif
      check("timeout_rdy", cmd_rdy, 1);

      RX = 1'b0; resp = 8'h3C; send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_tx", TX, 1);
      check("midrst_rdy", cmd_rdy, 0);
      check("midrst_cmd", cmd, 16'h0000);
      check("midrst_resp_sent", resp_sent, 0);
      RX = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_tx", TX, 1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      check("cmd_1234", cmd, 16'h1234);
      check("rdy_1234", cmd_rdy, 1);
      check("post_rst_tx_idle", TX, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
